// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the fetch (IF) and data (DM) ports.
// Data accesses have priority; a starvation counter forces a fetch grant, and a wait counter aborts stuck accesses.
module mem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 3,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_wen,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              timeout,
   output logic              busy
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
   localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e              state_q, state_d;
   logic                owner_dm_q, owner_dm_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [STV_W-1:0]    starve_cnt_q, starve_cnt_d;
   logic                if_ack_q, if_ack_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic                dm_ack_q, dm_ack_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_wen_q, mem_wen_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                timeout_q, timeout_d;
   logic                busy_q, busy_d;
   logic                grant_dm;
   logic                finish;
   logic [DATA_W-1:0]   rdata_v;

   always_comb begin
      state_d      = state_q;
      owner_dm_d   = owner_dm_q;
      wait_cnt_d   = wait_cnt_q;
      starve_cnt_d = starve_cnt_q;
      if_ack_d     = 1'b0;
      if_rdata_d   = if_rdata_q;
      dm_ack_d     = 1'b0;
      dm_rdata_d   = dm_rdata_q;
      mem_req_d    = mem_req_q;
      mem_wen_d    = mem_wen_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      timeout_d    = 1'b0;
      grant_dm     = 1'b0;
      finish       = 1'b0;
      rdata_v      = '0;

      unique case (state_q)
         IDLE: begin
            if (if_req || dm_req) begin
               grant_dm   = dm_req && (!if_req || (starve_cnt_q != STV_W'(STARVE_LIMIT)));
               owner_dm_d = grant_dm;
               state_d    = ACCESS;
               mem_req_d  = 1'b1;
               wait_cnt_d = WAIT_W'(1);
               if (grant_dm) begin
                  mem_wen_d   = dm_wen;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
                  if (!if_req)
                     starve_cnt_d = '0;
                  else if (starve_cnt_q != STV_W'(STARVE_LIMIT))
                     starve_cnt_d = starve_cnt_q + STV_W'(1);
               end else begin
                  mem_wen_d    = 1'b0;
                  mem_addr_d   = if_addr;
                  mem_wdata_d  = '0;
                  starve_cnt_d = '0;
               end
            end
         end
         ACCESS: begin
            // mem_ready wins over an expiring wait counter in the same cycle
            if (mem_ready) begin
               finish  = 1'b1;
               rdata_v = mem_wen_q ? '0 : mem_rdata;
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
               finish    = 1'b1;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            if (finish) begin
               mem_req_d = 1'b0;
               state_d   = RESP;
               if (owner_dm_q) begin
                  dm_ack_d   = 1'b1;
                  dm_rdata_d = rdata_v;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = rdata_v;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_dm_q   <= 1'b0;
         wait_cnt_q   <= '0;
         starve_cnt_q <= '0;
         if_ack_q     <= 1'b0;
         if_rdata_q   <= '0;
         dm_ack_q     <= 1'b0;
         dm_rdata_q   <= '0;
         mem_req_q    <= 1'b0;
         mem_wen_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         timeout_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_dm_q   <= owner_dm_d;
         wait_cnt_q   <= wait_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         if_ack_q     <= if_ack_d;
         if_rdata_q   <= if_rdata_d;
         dm_ack_q     <= dm_ack_d;
         dm_rdata_q   <= dm_rdata_d;
         mem_req_q    <= mem_req_d;
         mem_wen_q    <= mem_wen_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         timeout_q    <= timeout_d;
         busy_q       <= busy_d;
      end
   end

   assign if_ack    = if_ack_q;
   assign if_rdata  = if_rdata_q;
   assign dm_ack    = dm_ack_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign timeout   = timeout_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a cycle table for basic fetch/data traffic, then hand sequences for
// starvation, timeout, reset mid-access and ready-at-timeout.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        dm_req, dm_wen;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        mem_req, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        timeout, busy;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(3), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .timeout(timeout), .busy(busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

   // flags = {if_ack, dm_ack, mem_req, mem_wen, timeout, busy}
   typedef struct {
      logic        rst;
      logic        ifr;
      logic [31:0] ifa;
      logic        dmr;
      logic        dmw;
      logic [31:0] dma;
      logic [31:0] dmd;
      logic        rdy;
      logic [31:0] mrd;
      logic [5:0]  e_flags;
      logic [31:0] e_if_rdata;
      logic [31:0] e_dm_rdata;
      logic [31:0] e_mem_addr;
      logic [31:0] e_mem_wdata;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic ifr, input logic [31:0] ifa,
                               input logic dmr, input logic dmw, input logic [31:0] dma,
                               input logic [31:0] dmd, input logic rdy, input logic [31:0] mrd,
                               input logic [5:0] ef, input logic [31:0] eir, input logic [31:0] edr,
                               input logic [31:0] ema, input logic [31:0] emw);
      vec_t v;
      v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dmw = dmw; v.dma = dma;
      v.dmd = dmd; v.rdy = rdy; v.mrd = mrd; v.e_flags = ef; v.e_if_rdata = eir;
      v.e_dm_rdata = edr; v.e_mem_addr = ema; v.e_mem_wdata = emw;
      return v;
   endfunction

   function automatic logic [5:0] flags_now();
      return {if_ack, dm_ack, mem_req, mem_wen, timeout, busy};
   endfunction

   vec_t vecs[16];

   initial begin
      int nacks;
      int who[5];
      int exp_who[5];
      int hi;
      logic got;
      logic saw_ack;

      reset = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_wen = 0; dm_addr = '0;
      dm_wdata = '0; mem_ready = 0; mem_rdata = '0;

      //           rst ifr ifa    dmr dmw dma     dmd           rdy mrd           flags      if_rdata      dm_rdata      mem_addr mem_wdata
      vecs[0]  = mk(1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,        6'b000000, 32'h0,        32'h0,        32'h0,   32'h0);
      vecs[1]  = mk(0, 1, 32'h10, 0, 0, 32'h0,   32'h0,        0, 32'h0,        6'b001001, 32'h0,        32'h0,        32'h10,  32'h0);
      vecs[2]  = mk(0, 1, 32'h10, 0, 0, 32'h0,   32'h0,        1, 32'h00500093, 6'b100001, 32'h00500093, 32'h0,        32'h10,  32'h0);
      vecs[3]  = mk(0, 1, 32'h10, 0, 0, 32'h0,   32'h0,        0, 32'h0,        6'b000000, 32'h00500093, 32'h0,        32'h10,  32'h0);
      vecs[4]  = mk(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,        6'b000000, 32'h00500093, 32'h0,        32'h10,  32'h0);
      vecs[5]  = mk(0, 1, 32'h20, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,        6'b001101, 32'h00500093, 32'h0,        32'h100, 32'hDEADBEEF);
      vecs[6]  = mk(0, 1, 32'h20, 1, 1, 32'h100, 32'hDEADBEEF, 1, 32'h12345678, 6'b010101, 32'h00500093, 32'h0,        32'h100, 32'hDEADBEEF);
      vecs[7]  = mk(0, 1, 32'h20, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,        6'b000100, 32'h00500093, 32'h0,        32'h100, 32'hDEADBEEF);
      vecs[8]  = mk(0, 1, 32'h20, 0, 0, 32'h0,   32'h0,        0, 32'h0,        6'b001001, 32'h00500093, 32'h0,        32'h20,  32'h0);
      vecs[9]  = mk(0, 1, 32'h20, 0, 0, 32'h0,   32'h0,        1, 32'hCAFEF00D, 6'b100001, 32'hCAFEF00D, 32'h0,        32'h20,  32'h0);
      vecs[10] = mk(0, 1, 32'h20, 0, 0, 32'h0,   32'h0,        0, 32'h0,        6'b000000, 32'hCAFEF00D, 32'h0,        32'h20,  32'h0);
      vecs[11] = mk(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        1, 32'hFFFFFFFF, 6'b000000, 32'hCAFEF00D, 32'h0,        32'h20,  32'h0);
      vecs[12] = mk(0, 0, 32'h0,  1, 0, 32'h200, 32'h0,        0, 32'h0,        6'b001001, 32'hCAFEF00D, 32'h0,        32'h200, 32'h0);
      vecs[13] = mk(0, 0, 32'h0,  1, 0, 32'h200, 32'h0,        1, 32'hA5A5A5A5, 6'b010001, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h200, 32'h0);
      vecs[14] = mk(0, 0, 32'h0,  1, 0, 32'h200, 32'h0,        0, 32'h0,        6'b000000, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h200, 32'h0);
      vecs[15] = mk(0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,        6'b000000, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h200, 32'h0);

      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         reset = vecs[i].rst; if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
         dm_req = vecs[i].dmr; dm_wen = vecs[i].dmw; dm_addr = vecs[i].dma;
         dm_wdata = vecs[i].dmd; mem_ready = vecs[i].rdy; mem_rdata = vecs[i].mrd;
         @(posedge clk); #1;
         check($sformatf("vec%0d_flags", i),     flags_now(), vecs[i].e_flags);
         check($sformatf("vec%0d_if_rdata", i),  if_rdata,    vecs[i].e_if_rdata);
         check($sformatf("vec%0d_dm_rdata", i),  dm_rdata,    vecs[i].e_dm_rdata);
         check($sformatf("vec%0d_mem_addr", i),  mem_addr,    vecs[i].e_mem_addr);
         check($sformatf("vec%0d_mem_wdata", i), mem_wdata,   vecs[i].e_mem_wdata);
         @(negedge clk);
      end

      // Starvation: both ports always requesting; memory answers on the first ACCESS cycle.
      exp_who = '{1, 1, 1, 0, 1};
      who = '{default: -1};
      nacks = 0;
      if_req = 1; if_addr = 32'h40; dm_req = 1; dm_wen = 0; dm_addr = 32'h300;
      dm_wdata = '0; mem_rdata = 32'h11110000; mem_ready = 0;
      for (int c = 0; c < 60 && nacks < 5; c++) begin
         @(negedge clk);
         if (dm_ack) begin who[nacks] = 1; nacks++; end
         if (if_ack) begin who[nacks] = 0; nacks++; if_req = 0; end
         if (nacks >= 5) dm_req = 0;
         mem_ready = mem_req;
      end
      mem_ready = 0;
      check("starve_ack_count", nacks, 5);
      for (int i = 0; i < 5; i++)
         check($sformatf("starve_grant%0d_is_dm", i), who[i], exp_who[i]);
      @(negedge clk);

      // Timeout: fetch with memory never ready.
      if_req = 1; if_addr = 32'h80; mem_rdata = 32'hBAD0BAD0; mem_ready = 0;
      hi = 0; got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         if (if_ack) begin
            got = 1;
            check("to_pulse", timeout, 1);
            check("to_if_rdata", if_rdata, 0);
            check("to_mem_req_low", mem_req, 0);
            if_req = 0;
         end else if (mem_req) hi++;
      end
      check("to_ack_seen", got, 1);
      check("to_mem_req_cycles", hi, 64);
      @(negedge clk);
      check("to_pulse_width", timeout, 0);

      // Ready on the very cycle the wait counter reaches its limit.
      dm_req = 1; dm_wen = 0; dm_addr = 32'h400; mem_rdata = 32'h600DDA7A;
      hi = 0; got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         mem_ready = 0;
         if (dm_ack) begin
            got = 1;
            check("edge_timeout_low", timeout, 0);
            check("edge_dm_rdata", dm_rdata, 32'h600DDA7A);
            dm_req = 0;
         end else if (mem_req) begin
            hi++;
            if (hi == 64) mem_ready = 1;
         end
      end
      mem_ready = 0;
      check("edge_ack_seen", got, 1);
      @(negedge clk);

      // Reset while ACCESS is in progress.
      if_req = 1; if_addr = 32'h90; mem_ready = 0;
      for (int c = 0; c < 10 && !mem_req; c++) @(negedge clk);
      check("rst_access_entered", mem_req, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1; if_req = 0;
      @(posedge clk); #1;
      check("rst_flags_zero", flags_now(), 6'b000000);
      check("rst_mem_addr_zero", mem_addr, 0);
      check("rst_if_rdata_zero", if_rdata, 0);
      @(negedge clk);
      reset = 0;
      saw_ack = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (if_ack || dm_ack || mem_req) saw_ack = 1;
      end
      check("rst_no_ack_after", saw_ack, 0);
      if_req = 1; if_addr = 32'h94; mem_rdata = 32'h94949494;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (if_ack) begin
            got = 1;
            check("post_rst_if_rdata", if_rdata, 32'h94949494);
            check("post_rst_mem_addr", mem_addr, 32'h94);
            if_req = 0;
         end
         mem_ready = mem_req;
      end
      mem_ready = 0;
      check("post_rst_ack_seen", got, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
